// File: rtl/ifu_pc_gen_if.sv
// Instruction-fetch bus between the PC generator and instruction memory.
//   fetch_req_o    : fetch request (driven by the PC generator)
//   fetch_addr_o   : fetch address (driven by the PC generator)
//   fetch_gnt_i    : request accepted when fetch_req_o & fetch_gnt_i
//   fetch_rvalid_i : in-order response valid
//   fetch_rdata_i  : response instruction word
// master = PC generator side, slave = memory side.
interface ifu_pc_gen_if;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i;
  logic        fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;

  modport master (
    output fetch_req_o,
    output fetch_addr_o,
    input  fetch_gnt_i,
    input  fetch_rvalid_i,
    input  fetch_rdata_i
  );

  modport slave (
    input  fetch_req_o,
    input  fetch_addr_o,
    output fetch_gnt_i,
    output fetch_rvalid_i,
    output fetch_rdata_i
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator. Holds the PC, issues pipelined fetch requests
// (up to MAX_OUTSTANDING granted-but-unreturned), tracks in-flight addresses in a
// small FIFO, delivers responses as one-cycle inst_valid_o pulses, and discards
// responses that belong to fetches made stale by a redirect.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   jump_flag_i/addr_i: redirect request and target (branch unit / interrupt entry)
//   hold_i            : stall, blocks new requests only
//   fetch             : fetch bus (ifu_pc_gen_if.master)
//   inst_valid_o/inst_o/inst_addr_o : delivered instruction
//   misalign_o/misalign_addr_o      : misaligned-redirect report
//
// Optional feature: define JUMP_MISALIGN_CHECK_EN to halt fetching on a redirect
// to a non word-aligned target and report it; otherwise targets are force-aligned.
module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               hold_i,
  ifu_pc_gen_if.master       fetch,
  output logic               inst_valid_o,
  output logic [31:0]        inst_o,
  output logic [31:0]        inst_addr_o,
  output logic               misalign_o,
  output logic [31:0]        misalign_addr_o
);

  localparam logic [2:0] MaxCnt  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] LastPtr = 2'(MAX_OUTSTANDING - 1);

  logic [31:0] pc_q, pc_d;
  logic        started_q;
  logic        halted;
  logic [2:0]  outstanding_q, outstanding_d;
  logic [2:0]  kill_q, kill_d;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  // Sized for the largest legal depth; only the first MAX_OUTSTANDING slots are used.
  logic [31:0] fifo_q [4];
  logic        fetch_req, handshake, rsp, deliver;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  assign fetch_req = started_q & ~hold_i & ~jump_flag_i & ~halted & (outstanding_q < MaxCnt);
  assign fetch.fetch_req_o  = fetch_req;
  assign fetch.fetch_addr_o = pc_q;

  assign handshake = fetch_req & fetch.fetch_gnt_i;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp       = fetch.fetch_rvalid_i & (outstanding_q != 3'd0);
  assign deliver   = rsp & (kill_q == 3'd0) & ~jump_flag_i;

`ifdef JUMP_MISALIGN_CHECK_EN
  logic        halted_q;
  logic        misalign_jump;
  logic        misalign_q;
  logic [31:0] misalign_addr_q;

  assign misalign_jump   = jump_flag_i & (jump_addr_i[1:0] != 2'b00);
  assign halted          = halted_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  always_comb begin
    pc_d = pc_q;
    if (jump_flag_i) begin
      if (!misalign_jump) pc_d = jump_addr_i;
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q        <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
    end else begin
      misalign_q <= misalign_jump;
      if (jump_flag_i) halted_q <= misalign_jump;
      if (misalign_jump) misalign_addr_q <= jump_addr_i;
    end
  end
`else
  logic unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr_i[1:0];
  assign halted           = 1'b0;
  assign misalign_o       = 1'b0;
  assign misalign_addr_o  = 32'd0;

  always_comb begin
    pc_d = pc_q;
    if (jump_flag_i) begin
      pc_d = {jump_addr_i[31:2], 2'b00};
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end
  end
`endif

  always_comb begin
    outstanding_d = outstanding_q + {2'b00, handshake} - {2'b00, rsp};
    kill_d        = kill_q;
    if (jump_flag_i) begin
      // Everything still in flight after this cycle's response is stale.
      kill_d = outstanding_q - {2'b00, rsp};
    end else if (rsp && kill_q != 3'd0) begin
      kill_d = kill_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      started_q     <= 1'b0;
      outstanding_q <= 3'd0;
      kill_q        <= 3'd0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 32'd0;
      inst_valid_o  <= 1'b0;
      inst_o        <= 32'd0;
      inst_addr_o   <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      started_q     <= 1'b1;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      if (handshake) begin
        fifo_q[wr_ptr_q] <= pc_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (rsp) rd_ptr_q <= ptr_inc(rd_ptr_q);
      inst_valid_o <= deliver;
      if (deliver) begin
        inst_o      <= fetch.fetch_rdata_i;
        inst_addr_o <= fifo_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_ifu_pc_gen.sv
module tb_ifu_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag, hold;
  logic [31:0] jump_addr;
  logic        inst_valid, misalign;
  logic [31:0] inst, inst_addr, misalign_addr;

  ifu_pc_gen_if fetch_bus ();

  ifu_pc_gen #(
    .RESET_PC        (RESET_PC),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_i     (jump_flag),
    .jump_addr_i     (jump_addr),
    .hold_i          (hold),
    .fetch           (fetch_bus),
    .inst_valid_o    (inst_valid),
    .inst_o          (inst),
    .inst_addr_o     (inst_addr),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected PC, in-flight address list with a stale flag per
  // entry, and the expected registered outputs for the next observation.
  logic [31:0] m_pc;
  bit          m_started, m_halted;
  logic [31:0] m_q[$];
  bit          m_stale[$];
  bit          m_valid, m_mis;
  logic [31:0] m_iaddr, m_inst, m_mis_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_started = 0; m_halted = 0;
    m_q.delete(); m_stale.delete();
    m_valid = 0; m_iaddr = 0; m_inst = 0; m_mis = 0; m_mis_addr = 0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // across the following rising edge.
  task automatic cycle(input bit h, input bit j, input logic [31:0] ja, input bit g, input bit r);
    bit          exp_req, hs, nv, nmis;
    logic [31:0] a;
    bit          s;
    @(negedge clk);
    hold = h; jump_flag = j; jump_addr = ja;
    fetch_bus.fetch_gnt_i    = g;
    fetch_bus.fetch_rvalid_i = r;
    fetch_bus.fetch_rdata_i  = (r && m_q.size() > 0) ? mem_word(m_q[0]) : $urandom();
    #1;
    exp_req = m_started && !h && !j && !m_halted && (m_q.size() < MAX_OUT);
    check("fetch_req", {31'd0, fetch_bus.fetch_req_o}, {31'd0, exp_req});
    if (exp_req) check("fetch_addr", fetch_bus.fetch_addr_o, m_pc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("inst_addr", inst_addr, m_iaddr);
      check("inst", inst, m_inst);
    end
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
`ifdef JUMP_MISALIGN_CHECK_EN
    if (m_mis) check("misalign_addr", misalign_addr, m_mis_addr);
`else
    check("misalign_addr", misalign_addr, 32'd0);
`endif
    hs = exp_req && g;
    nv = 0; nmis = 0;
    if (r && m_q.size() > 0) begin
      a = m_q.pop_front();
      s = m_stale.pop_front();
      if (!s && !j) begin
        nv = 1; m_iaddr = a; m_inst = mem_word(a);
      end
    end
    if (j) begin
      foreach (m_stale[i]) m_stale[i] = 1;
`ifdef JUMP_MISALIGN_CHECK_EN
      if (ja[1:0] != 2'b00) begin
        m_halted = 1; nmis = 1; m_mis_addr = ja;
      end else begin
        m_halted = 0; m_pc = ja;
      end
`else
      m_pc = {ja[31:2], 2'b00};
`endif
    end else if (hs) begin
      m_q.push_back(m_pc);
      m_stale.push_back(0);
      m_pc = m_pc + 32'd4;
    end
    m_valid = nv;
    m_mis   = nmis;
    m_started = 1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1; hold = 0; jump_flag = 0; jump_addr = 0;
    fetch_bus.fetch_gnt_i = 0; fetch_bus.fetch_rvalid_i = 0; fetch_bus.fetch_rdata_i = 0;
    #1;
    check("rst_req", {31'd0, fetch_bus.fetch_req_o}, 32'd0);
    check("rst_pc", fetch_bus.fetch_addr_o, RESET_PC);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("req_before_start", {31'd0, fetch_bus.fetch_req_o}, 32'd0);
    model_reset();
    // The next rising edge (idle inputs) sets started.
    m_started = 1;
  endtask

  initial begin
    logic [31:0] ja;
    model_reset();
    do_reset();

    // Sequential fetch with a response one cycle after each grant.
    repeat (8) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Outstanding limit: grants only, no responses.
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 1, 0);

    // Redirect with two in flight; both stale responses dropped.
    cycle(0, 1, 32'h100, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Redirect coinciding with a response while two are in flight.
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h300, 1, 1);
    cycle(0, 0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Hold with one in flight; the response is still delivered.
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    repeat (2) cycle(1, 0, 0, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Misaligned redirect, then an aligned one.
    cycle(0, 1, 32'h102, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, m_q.size() > 0);
    cycle(0, 1, 32'h200, 1, m_q.size() > 0);
    repeat (4) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Back-to-back redirects, and PC wrap past the top of memory.
    cycle(0, 1, 32'h400, 1, m_q.size() > 0);
    cycle(0, 1, 32'hFFFF_FFF8, 1, m_q.size() > 0);
    repeat (6) cycle(0, 0, 0, 1, m_q.size() > 0);

    // Random traffic, including responses with nothing in flight.
    for (int n = 0; n < 600; n++) begin
      ja = $urandom();
      if ($urandom_range(3) != 0) ja[1:0] = 2'b00;
      cycle($urandom_range(4) == 0, $urandom_range(9) == 0, ja,
            $urandom_range(9) < 7, $urandom_range(1) == 1);
    end

    // Reset with traffic in flight; a later stray response must be ignored.
    repeat (2) cycle(0, 0, 0, 1, 0);
    do_reset();
    cycle(0, 0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, m_q.size() > 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_pc_gen.md
IFU_PC_GEN -- requirements
Module: ifu_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..4, maximum granted-but-unreturned fetches.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port jump_flag_i  input  1  redirect request from the branch unit, including interrupt entry.
REQ-006 SHALL have port jump_addr_i  input  32  redirect target, valid when jump_flag_i=1.
REQ-007 SHALL have port hold_i  input  1  pipeline stall; blocks new fetch requests.
REQ-008 SHALL have port fetch_req_o  output  1  fetch request to instruction memory.
REQ-009 SHALL have port fetch_addr_o  output  32  fetch address, equal to the current PC.
REQ-010 SHALL have port fetch_gnt_i  input  1  request accepted when fetch_req_o&fetch_gnt_i.
REQ-011 SHALL have ports fetch_rvalid_i (input, 1) and fetch_rdata_i (input, 32): in-order response and data.
REQ-012 SHALL have port inst_valid_o  output  1  one-cycle pulse per delivered instruction.
REQ-013 SHALL have port inst_o  output  32  delivered instruction word.
REQ-014 SHALL have port inst_addr_o  output  32  address of inst_o.
REQ-015 SHALL have ports misalign_o (output, 1) and misalign_addr_o (output, 32): misaligned-target report (see Configuration).

Function
REQ-016 SHALL hold the PC register; fetch_addr_o = PC combinationally.
REQ-017 SHALL assert fetch_req_o = started & ~hold_i & ~jump_flag_i & ~halted & (outstanding < MAX_OUTSTANDING).
REQ-018 SHALL set started to 1 on the first rising edge after rst deasserts, so the first request appears in the first cycle after that edge.
REQ-019 On a handshake (fetch_req_o&fetch_gnt_i), SHALL: advance PC by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0); push the fetch address into an address FIFO of depth MAX_OUTSTANDING; increment outstanding.
REQ-020 On fetch_rvalid_i, SHALL pop the FIFO and decrement outstanding; a handshake and a response in the same cycle leave outstanding unchanged.
REQ-021 On a popped response with kill_cnt=0 and no jump that cycle, SHALL register inst_o=fetch_rdata_i, inst_addr_o=the popped address and inst_valid_o=1 for exactly one cycle (latency: 1 cycle from rvalid).
REQ-022 On a popped response with kill_cnt>0, SHALL drop it (inst_valid_o=0) and decrement kill_cnt.
REQ-023 On jump_flag_i=1, SHALL load PC from jump_addr_i, taking priority over the +4 increment, and issue no request that cycle.
REQ-024 On jump_flag_i=1, SHALL set kill_cnt = outstanding - fetch_rvalid_i, and drop a response arriving in the jump cycle.
REQ-025 Jumps in consecutive cycles SHALL each recompute kill_cnt; only the last target is fetched.
REQ-026 hold_i SHALL block only new requests; in-flight responses are still accepted and delivered or dropped per REQ-021/REQ-022.
REQ-027 fetch_rvalid_i with outstanding=0 is a protocol error; the block SHALL ignore it (no pop, no pulse).

Reset
REQ-028 While rst=1, SHALL force PC=RESET_PC, started=0, outstanding=0, kill_cnt=0, FIFO empty, halted=0, fetch_req_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, misalign_o=0, misalign_addr_o=0.
REQ-029 Reset asserted mid-transaction SHALL discard all in-flight state; responses arriving after reset release with outstanding=0 follow REQ-027.

Configuration
REQ-030 With JUMP_MISALIGN_CHECK_EN defined, SHALL handle a jump with jump_addr_i[1:0]!=0 as follows:
- no PC load; set halted=1;
- register misalign_o=1 for one cycle and misalign_addr_o=jump_addr_i;
- apply kill handling per REQ-024;
- the next aligned jump clears halted.
REQ-031 Without JUMP_MISALIGN_CHECK_EN, SHALL load PC={jump_addr_i[31:2],2'b00}, never set halted, and tie misalign_o and misalign_addr_o to 0.

Verification
REQ-032 Reset release, gnt=1, rvalid one cycle after each gnt -> fetch addresses 0x0,0x4,0x8; inst_valid_o pulses with inst_addr_o 0x0,0x4,0x8 in order.
REQ-033 MAX_OUTSTANDING=2, gnt=1, rvalid=0 -> exactly two handshakes (0x0,0x4); fetch_req_o then stays 0 until an rvalid.
REQ-034 Two outstanding fetches, jump to 0x100 -> no request in the jump cycle; both stale responses dropped; next fetch is 0x100 and the next inst_valid_o has inst_addr_o=0x100.
REQ-035 Jump coinciding with rvalid while 2 outstanding -> that response dropped; kill_cnt=1; one further response dropped.
REQ-036 hold_i=1 for 5 cycles with 1 outstanding -> no requests; the pending response is still delivered; fetches resume at the next PC when hold_i=0.
REQ-037 Macro on: jump to 0x102 -> misalign_o pulses with misalign_addr_o=0x102 and fetching halts; jump to 0x200 resumes fetching. Macro off: fetching resumes at 0x100.
